// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit between the PC register and decode.
// Optional performance counters (fetch_cnt, stall_cnt) are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_STEP = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [ADDR_W-1:0]  pc,
  output logic               pc_load,
  output logic [ADDR_W-1:0]  pc_next,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               stall,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt,
`endif
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 drop_q, drop_d;
  logic                 instr_valid_q, instr_valid_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]    instr_pc_q, instr_pc_d;

  logic                 buf_free;
  logic                 rsp_load;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    drop_d        = drop_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;

    buf_free = !instr_valid_q || instr_ready;
    // A branch wins over a response arriving in the same cycle.
    rsp_load = (state_q == S_WAIT) && imem_rvalid && !branch_taken;

    // A response owed to a killed request retires the drop flag; a stray one
    // with no flag pending (e.g. issued before reset) is simply ignored.
    if (drop_q && imem_rvalid) drop_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!stall && buf_free && !branch_taken && !drop_q) begin
          state_d = S_REQ;
          addr_d  = pc;
        end
      end
      S_REQ: begin
        if (branch_taken) begin
          state_d = S_IDLE;
          if (imem_gnt) drop_d = 1'b1;
        end else if (imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (branch_taken) begin
          state_d = S_IDLE;
          if (!imem_rvalid) drop_d = 1'b1;
        end else if (imem_rvalid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (instr_valid_q && instr_ready) instr_valid_d = 1'b0;
    if (rsp_load) begin
      instr_valid_d = 1'b1;
      instr_d       = imem_rdata;
      instr_pc_d    = addr_q;
    end
    if (branch_taken) instr_valid_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  // NOTE: the buffer data is reset too, because the outputs must read zero in reset.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      drop_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      drop_q        <= drop_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  // The redirect path is combinational from branch_taken, so it is gated to
  // keep the PC write strobe quiet while clr is held.
  always_comb begin
    pc_load = clr && (branch_taken || rsp_load);
    pc_next = '0;
    if (clr && branch_taken)  pc_next = branch_target;
    else if (clr && rsp_load) pc_next = addr_q + STEP;
  end

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = addr_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (rsp_load) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (((state_q == S_REQ) && !imem_gnt) || (instr_valid_q && !instr_ready))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC register and memory responder models, a transaction-level
// reference checked every cycle, and directed scenarios with literal expectations.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] pc;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit dut (
    .clk(clk), .clr(clr), .pc(pc), .pc_load(pc_load), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- environment: PC register + instruction memory ----------------
  logic [31:0] pc_reg;
  int          force_req = 0;
  logic [31:0] force_val = '0;
  logic        ld_seen = 1'b0;
  logic [31:0] ld_val = '0;
  int          gnt_lat = 0;
  int          rv_lat = 1;
  logic [31:0] rdata_ovr = '0;

  assign pc = pc_reg;

  initial begin
    int force_ack;
    int req_age;
    int rv_cnt;
    bit mem_pend;
    force_ack = 0; req_age = 0; rv_cnt = 0; mem_pend = 0;
    pc_reg = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (force_req != force_ack) begin
        pc_reg    = force_val;
        force_ack = force_req;
      end else if (ld_seen) begin
        pc_reg = ld_val;
      end
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      if (mem_pend) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = rdata_ovr;
          mem_pend    = 0;
        end
      end
      if (imem_req && !mem_pend) begin
        if (req_age >= gnt_lat) begin
          imem_gnt = 1'b1;
          mem_pend = 1;
          rv_cnt   = rv_lat;
          req_age  = 0;
        end else begin
          req_age++;
        end
      end else begin
        req_age = 0;
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  // Transaction view: which request is outstanding and whether it is still
  // wanted, plus the contents of the one-entry instruction buffer.
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = '0, m_pc = '0;
  logic        o_pend = 1'b0, o_live = 1'b0;
  logic [31:0] o_addr = '0;
  logic        prev_req = 1'b0, prev_gnt = 1'b0, prev_branch = 1'b0;
  logic        prev_stall = 1'b1, prev_free = 1'b1;
  logic [31:0] prev_pc = '0, prev_addr = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!clr) begin
        check("rst_ctrl", {29'd0, pc_load, imem_req, instr_valid}, 32'd0);
        check("rst_data", pc_next | imem_addr | instr | instr_pc, 32'd0);
        m_valid = 1'b0;
        o_live  = 1'b0;
        if (imem_rvalid) o_pend = 1'b0;
        prev_req = 1'b0;
        prev_gnt = 1'b0;
      end else begin
        logic live_rsp;
        logic exp_ld;
        if (prev_req) begin
          check("req_hold", imem_req, !prev_gnt && !prev_branch);
          if (imem_req) check("req_addr_hold", imem_addr, prev_addr);
        end else if (imem_req) begin
          check("req_gate", {prev_stall, prev_branch, !prev_free, o_pend && o_live}, 32'd0);
          check("req_addr", imem_addr, prev_pc);
        end
        live_rsp = imem_rvalid && o_pend && o_live;
        exp_ld   = branch_taken || live_rsp;
        check("pc_load", pc_load, exp_ld);
        if (exp_ld) check("pc_next", pc_next, branch_taken ? branch_target : o_addr + 32'd4);
        check("instr_valid", instr_valid, m_valid);
        if (m_valid) begin
          check("instr", instr, m_instr);
          check("instr_pc", instr_pc, m_pc);
        end
        prev_free = !m_valid || instr_ready;
        if (branch_taken) m_valid = 1'b0;
        else if (live_rsp) begin
          m_valid = 1'b1;
          m_instr = imem_rdata;
          m_pc    = o_addr;
        end else if (m_valid && instr_ready) m_valid = 1'b0;
        if (imem_rvalid) o_pend = 1'b0;
        if (branch_taken) o_live = 1'b0;
        if (imem_req && imem_gnt) begin
          o_pend = 1'b1;
          o_live = !branch_taken;
          o_addr = imem_addr;
        end
        prev_req = imem_req;
        prev_gnt = imem_gnt;
      end
      if (!clr) prev_free = 1'b1;
      prev_branch = branch_taken;
      prev_stall  = stall;
      prev_pc     = pc_reg;
      prev_addr   = imem_addr;
      ld_seen     = pc_load;
      ld_val      = pc_next;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_grant(input string nm, input int budget, output logic [31:0] a);
    bit seen;
    seen = 0;
    a = '0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) begin
        seen = 1;
        a    = imem_addr;
      end
    end
    check({nm, "_gnt_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_load(input string nm, input int budget, output logic [31:0] nxt, output int n);
    bit seen;
    seen = 0;
    nxt = '0;
    n = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      n = i + 1;
      if (pc_load) begin
        seen = 1;
        nxt  = pc_next;
      end
    end
    check({nm, "_load_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic set_pc(input logic [31:0] v);
    force_val = v;
    force_req++;
    cyc();
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, nx;
    int n;
    clr = 1'b0; stall = 1'b1; instr_ready = 1'b1;
    branch_taken = 1'b0; branch_target = '0;
    force_val = 32'h10;
    force_req = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req", imem_req, 32'd0);
    check("reset_valid", instr_valid, 32'd0);
    check("reset_pc_load", pc_load, 32'd0);
    cyc(); clr = 1'b1;
    cyc(); cyc();

    // Sequential fetch at 0x10, zero-wait grant, data one cycle later.
    rdata_ovr = 32'hDEADBEEF; gnt_lat = 0; rv_lat = 1; stall = 1'b0;
    wait_grant("seq", 10, a);
    check("seq_req_addr", a, 32'h10);
    wait_load("seq", 5, nx, n);
    check("seq_pc_next", nx, 32'h14);
    cyc(); stall = 1'b1;
    @(negedge clk);
    check("seq_instr_valid", instr_valid, 32'd1);
    check("seq_instr", instr, 32'hDEADBEEF);
    check("seq_instr_pc", instr_pc, 32'h10);

    // Back-to-back: one instruction every three cycles.
    cyc(); rdata_ovr = 32'h11111111; stall = 1'b0;
    wait_load("b2b1", 10, nx, n);
    check("b2b1_pc_next", nx, 32'h18);
    wait_load("b2b2", 10, nx, n);
    check("b2b2_pc_next", nx, 32'h1C);
    check("b2b_period", n, 32'd3);
    cyc(); stall = 1'b1;

    // Backpressure: decode refuses for five cycles.
    cyc(); instr_ready = 1'b0; rdata_ovr = 32'h22222222;
    cyc(); stall = 1'b0;
    wait_load("bp", 10, nx, n);
    check("bp_pc_next", nx, 32'h20);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", instr_valid, 32'd1);
      check("bp_no_req", imem_req, 32'd0);
    end
    cyc(); instr_ready = 1'b1;
    @(negedge clk);
    check("bp_instr", instr, 32'h22222222);
    check("bp_instr_pc", instr_pc, 32'h1C);
    @(negedge clk);
    check("bp_req_resume", imem_req, 32'd1);
    check("bp_req_addr", imem_addr, 32'h20);
    cyc(); stall = 1'b1;
    wait_load("bp_drain", 6, nx, n);
    check("bp_drain_pc_next", nx, 32'h24);

    // Branch while waiting for data: response discarded, refetch from target.
    rv_lat = 3; rdata_ovr = 32'h12345678;
    cyc(); stall = 1'b0;
    wait_grant("br", 10, a);
    check("br_req_addr", a, 32'h24);
    cyc(); branch_taken = 1'b1; branch_target = 32'h200;
    @(negedge clk);
    check("br_pc_load", pc_load, 32'd1);
    check("br_pc_next", pc_next, 32'h200);
    cyc(); branch_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("br_discard_load", pc_load, 32'd0);
      check("br_discard_valid", instr_valid, 32'd0);
    end
    rdata_ovr = 32'hCAFEF00D;
    wait_grant("br_refetch", 10, a);
    check("br_refetch_addr", a, 32'h200);
    cyc(); stall = 1'b1;
    wait_load("br_refetch", 8, nx, n);
    check("br_refetch_pc_next", nx, 32'h204);
    @(negedge clk);
    check("br_refetch_instr", instr, 32'hCAFEF00D);
    check("br_refetch_instr_pc", instr_pc, 32'h200);

    // Address wrap.
    rv_lat = 1; rdata_ovr = 32'h0BADC0DE;
    set_pc(32'hFFFFFFFC);
    stall = 1'b0;
    wait_grant("wrap", 10, a);
    check("wrap_req_addr", a, 32'hFFFFFFFC);
    cyc(); stall = 1'b1;
    wait_load("wrap", 5, nx, n);
    check("wrap_pc_next", nx, 32'h0);

    // Stall raised during WAIT: response completes, then no new request.
    rv_lat = 3; rdata_ovr = 32'h33333333;
    cyc(); stall = 1'b0;
    wait_grant("stw", 10, a);
    check("stw_req_addr", a, 32'h0);
    cyc(); stall = 1'b1;
    wait_load("stw", 6, nx, n);
    check("stw_pc_next", nx, 32'h4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stw_no_req", imem_req, 32'd0);
    end
    cyc(); stall = 1'b0;
    wait_grant("stw_resume", 5, a);
    check("stw_resume_addr", a, 32'h4);
    cyc(); stall = 1'b1;
    wait_load("stw_resume", 6, nx, n);
    check("stw_resume_pc_next", nx, 32'h8);

    // Reset mid-WAIT: outputs clear at once, late response ignored.
    rdata_ovr = 32'h44444444;
    cyc(); stall = 1'b0;
    wait_grant("rst", 10, a);
    check("rst_req_addr", a, 32'h8);
    @(posedge clk); #2; clr = 1'b0; stall = 1'b1;
    #1;
    check("rst_async_req", imem_req, 32'd0);
    check("rst_async_load", pc_load, 32'd0);
    check("rst_async_addr", imem_addr, 32'd0);
    cyc(); clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_stale_load", pc_load, 32'd0);
      check("rst_stale_valid", instr_valid, 32'd0);
    end
    rdata_ovr = 32'h55555555;
    cyc(); stall = 1'b0;
    wait_grant("rst_re", 10, a);
    check("rst_re_addr", a, 32'h8);
    cyc(); stall = 1'b1;
    wait_load("rst_re", 6, nx, n);
    check("rst_re_pc_next", nx, 32'hC);
    @(negedge clk);
    check("rst_re_instr", instr, 32'h55555555);
    check("rst_re_instr_pc", instr_pc, 32'h8);

    // Branch in REQ before grant: request withdrawn, refetch at target.
    gnt_lat = 2; rv_lat = 1; rdata_ovr = 32'h66666666;
    cyc(); stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("wd_req_pending", {30'd0, imem_req, imem_gnt}, 32'd2);
    cyc(); branch_taken = 1'b1; branch_target = 32'h300;
    @(negedge clk);
    check("wd_pc_next", pc_next, 32'h300);
    cyc(); branch_taken = 1'b0;
    wait_grant("wd", 10, a);
    check("wd_refetch_addr", a, 32'h300);
    cyc(); stall = 1'b1;
    wait_load("wd", 5, nx, n);
    check("wd_pc_next_seq", nx, 32'h304);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
